// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package cpu_bus_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] ST_FREE     = 2'd0;
  localparam logic [1:0] ST_LOCKED_I = 2'd1;
  localparam logic [1:0] ST_LOCKED_D = 2'd2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order owner tracking for accepted address phases; 1-bit entries, push and pop may coincide.
module arb_owner_fifo
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  owner_e push_owner,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output owner_e head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  owner_e          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // When full, the slot being written is the head being popped this cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= OWNER_INST;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_owner;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one SRAM-like port between fetch and data requesters; responses return in accept order.
// Fixed data priority by default; BUS_ARB_RR_EN selects round-robin on ties.
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        protocol_err
);

  logic [1:0] state_q, state_d;
  logic       grant_vld;
  owner_e     grant_own;
  logic       fifo_full, fifo_empty;
  owner_e     fifo_head;
  logic       push, pop;
  logic       err_q, err_d;
  req_t       sel_req;
`ifdef BUS_ARB_RR_EN
  owner_e     last_q, last_d;
`endif

  always_comb begin
    grant_vld = 1'b0;
    grant_own = OWNER_INST;
    case (state_q)
      ST_LOCKED_I: grant_vld = 1'b1;
      ST_LOCKED_D: begin
        grant_vld = 1'b1;
        grant_own = OWNER_DATA;
      end
      default: begin
        if (!fifo_full && (inst_req || data_req)) begin
          grant_vld = 1'b1;
`ifdef BUS_ARB_RR_EN
          if (inst_req && data_req) begin
            if (last_q == OWNER_INST) grant_own = OWNER_DATA;
          end else if (data_req) begin
            grant_own = OWNER_DATA;
          end
`else
          if (data_req) grant_own = OWNER_DATA;
`endif
        end
      end
    endcase
    if (!resetn) grant_vld = 1'b0;
  end

  always_comb begin
    sel_req = '0;
    if (grant_vld) begin
      if (grant_own == OWNER_DATA)
        sel_req = '{wr: data_wr, size: data_size, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};
      else
        sel_req = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
    end
  end

  assign bus_req   = grant_vld;
  assign bus_wr    = sel_req.wr;
  assign bus_size  = sel_req.size;
  assign bus_wstrb = sel_req.wstrb;
  assign bus_addr  = sel_req.addr;
  assign bus_wdata = sel_req.wdata;

  assign push = grant_vld & bus_addr_ok;
  assign pop  = bus_data_ok & ~fifo_empty;

  assign inst_addr_ok = push & (grant_own == OWNER_INST);
  assign data_addr_ok = push & (grant_own == OWNER_DATA);
  assign inst_data_ok = pop & (fifo_head == OWNER_INST);
  assign data_data_ok = pop & (fifo_head == OWNER_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign err_d        = err_q | (bus_data_ok & fifo_empty);
  assign protocol_err = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FREE: begin
        if (grant_vld && !bus_addr_ok)
          state_d = (grant_own == OWNER_DATA) ? ST_LOCKED_D : ST_LOCKED_I;
      end
      ST_LOCKED_I, ST_LOCKED_D: begin
        if (bus_addr_ok) state_d = ST_FREE;
      end
      default: state_d = ST_FREE;
    endcase
  end

`ifdef BUS_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (push) last_d = grant_own;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_FREE;
      err_q   <= 1'b0;
`ifdef BUS_ARB_RR_EN
      last_q  <= OWNER_INST;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
`ifdef BUS_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (push),
    .push_owner(grant_own),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference of the arbiter.
module tb_cpu_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic resetn;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size, bus_size;
  logic [3:0] inst_wstrb, data_wstrb, bus_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic bus_req, bus_wr, bus_addr_ok, bus_data_ok, protocol_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int total = 0;
  int bad   = 0;

  // Reference state: issue-order owner queue, pending unaccepted grant, sticky error, last winner.
  bit mq[$];
  int m_lock;
  bit m_err;
  bit m_last;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .protocol_err(protocol_err)
  );

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = SIZE_W; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = SIZE_W; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    resetn = 0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1;
    mq.delete(); m_lock = -1; m_err = 0; m_last = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 0;
    inst_req = 1; data_req = 1; data_addr = 32'h44; bus_addr_ok = 1; bus_data_ok = 1;
    #2;
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    total++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0)
      begin bad++; $display("FAIL reset_oks: got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
    total++; if (bus_addr !== 32'h0 || protocol_err !== 1'b0)
      begin bad++; $display("FAIL reset_payload_err: got addr=%h err=%b want 0/0", bus_addr, protocol_err); end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_inst_single();
    apply_reset();
    inst_req = 1; inst_addr = 32'h1C00_0000; bus_addr_ok = 1;
    #2;
    total++; if (bus_req !== 1'b1 || bus_addr !== 32'h1C00_0000)
      begin bad++; $display("FAIL single_bus: got req=%b addr=%h want 1/1c000000", bus_req, bus_addr); end
    total++; if ({inst_addr_ok, data_addr_ok} !== 2'b10)
      begin bad++; $display("FAIL single_addr_ok: got %b want 10", {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
    #2;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL single_resp: got ok=%b rdata=%h want 10/deadbeef", {inst_data_ok, data_data_ok}, inst_rdata); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_priority();
    apply_reset();
    inst_req = 1; inst_addr = 32'h1C00_0004; data_req = 1; data_addr = 32'h80; bus_addr_ok = 1;
    #2;
    total++; if (bus_addr !== 32'h80 || {inst_addr_ok, data_addr_ok} !== 2'b01)
      begin bad++; $display("FAIL prio_first: got addr=%h ok=%b want 80/01", bus_addr, {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    data_req = 0;
    #2;
    total++; if (bus_addr !== 32'h1C00_0004 || {inst_addr_ok, data_addr_ok} !== 2'b10)
      begin bad++; $display("FAIL prio_second: got addr=%h ok=%b want 1c000004/10", bus_addr, {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    inst_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1111_1111;
    #2;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b01)
      begin bad++; $display("FAIL prio_resp1: got %b want 01", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    bus_rdata = 32'h2222_2222;
    #2;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b10)
      begin bad++; $display("FAIL prio_resp2: got %b want 10", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_lock();
    apply_reset();
    inst_req = 1; inst_addr = 32'h1C00_0010;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin data_req = 1; data_addr = 32'h90; end
      #2;
      total++; if (bus_addr !== 32'h1C00_0010 || {inst_addr_ok, data_addr_ok} !== 2'b00)
        begin bad++; $display("FAIL lock_hold%0d: got addr=%h ok=%b want 1c000010/00", c, bus_addr, {inst_addr_ok, data_addr_ok}); end
      @(negedge clk);
    end
    bus_addr_ok = 1;
    #2;
    total++; if (bus_addr !== 32'h1C00_0010 || {inst_addr_ok, data_addr_ok} !== 2'b10)
      begin bad++; $display("FAIL lock_accept: got addr=%h ok=%b want 1c000010/10", bus_addr, {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    inst_req = 0;
    #2;
    total++; if (bus_addr !== 32'h90 || {inst_addr_ok, data_addr_ok} !== 2'b01)
      begin bad++; $display("FAIL lock_next: got addr=%h ok=%b want 90/01", bus_addr, {inst_addr_ok, data_addr_ok}); end
    @(negedge clk);
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #2;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b10)
      begin bad++; $display("FAIL lock_resp1: got %b want 10", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    #2;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b01)
      begin bad++; $display("FAIL lock_resp2: got %b want 01", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_full();
    apply_reset();
    data_req = 1; bus_addr_ok = 1;
    data_addr = 32'hA0; @(negedge clk);
    data_addr = 32'hA4; @(negedge clk);
    data_addr = 32'hA8;
    #2;
    total++; if (bus_req !== 1'b0 || data_addr_ok !== 1'b0 || bus_addr !== 32'h0)
      begin bad++; $display("FAIL full_block: got req=%b ok=%b addr=%h want 0/0/0", bus_req, data_addr_ok, bus_addr); end
    @(negedge clk);
    bus_data_ok = 1;
    #2;
    total++; if (bus_req !== 1'b0 || data_data_ok !== 1'b1)
      begin bad++; $display("FAIL full_pop_nogrant: got req=%b dok=%b want 0/1", bus_req, data_data_ok); end
    @(negedge clk);
    #2;
    total++; if ({data_addr_ok, data_data_ok} !== 2'b11)
      begin bad++; $display("FAIL push_pop_same: got %b want 11", {data_addr_ok, data_data_ok}); end
    @(negedge clk);
    data_req = 0; bus_data_ok = 0; inst_req = 1; inst_addr = 32'hAC;
    #2;
    total++; if (inst_addr_ok !== 1'b1)
      begin bad++; $display("FAIL occ_after_pp: got %b want 1", inst_addr_ok); end
    @(negedge clk);
    inst_req = 0; data_req = 1; data_addr = 32'hB0;
    #2;
    total++; if (bus_req !== 1'b0)
      begin bad++; $display("FAIL full_again: got %b want 0", bus_req); end
    @(negedge clk);
    data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
    #2;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b01)
      begin bad++; $display("FAIL full_drain1: got %b want 01", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    #2;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b10)
      begin bad++; $display("FAIL full_drain2: got %b want 10", {inst_data_ok, data_data_ok}); end
    @(negedge clk);
    bus_data_ok = 0;
    #2;
    total++; if (protocol_err !== 1'b0)
      begin bad++; $display("FAIL full_no_err: got %b want 0", protocol_err); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_spurious();
    apply_reset();
    bus_data_ok = 1; bus_addr_ok = 1; inst_req = 1; inst_addr = 32'h1C00_0020;
    #2;
    total++; if ({inst_data_ok, data_data_ok} !== 2'b00 || protocol_err !== 1'b0)
      begin bad++; $display("FAIL spur_route: got ok=%b err=%b want 00/0", {inst_data_ok, data_data_ok}, protocol_err); end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    #2;
    total++; if (protocol_err !== 1'b1)
      begin bad++; $display("FAIL spur_sticky: got %b want 1", protocol_err); end
    resetn = 0;
    #1;
    total++; if (protocol_err !== 1'b0)
      begin bad++; $display("FAIL spur_clear: got %b want 0", protocol_err); end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_tie();
    logic [3:0] exp_d;
    apply_reset();
`ifdef BUS_ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    inst_req = 1; inst_addr = 32'h1C00_0100; data_req = 1; data_addr = 32'h200; bus_addr_ok = 1;
    for (int c = 0; c < 4; c++) begin
      bus_data_ok = (c > 0);
      #2;
      total++; if (data_addr_ok !== exp_d[c] || inst_addr_ok !== ~exp_d[c])
        begin bad++; $display("FAIL tie_grant%0d: got d=%b i=%b want d=%b", c, data_addr_ok, inst_addr_ok, exp_d[c]); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit i_act, d_act, ev, eo, e_idk, e_ddk, e_ia, e_da, e_err;
    logic [5:0]   got_hs, exp_hs;
    logic [134:0] got_pl, exp_pl;
    logic [1:0]   sizes [3];
    sizes[0] = SIZE_B; sizes[1] = SIZE_H; sizes[2] = SIZE_W;
    apply_reset();
    i_act = 0; d_act = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      resetn = ($urandom_range(299) != 0);
      if (!i_act && $urandom_range(2) == 0) begin
        i_act = 1; inst_wr = 0; inst_size = sizes[$urandom_range(2)];
        inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!d_act && $urandom_range(2) == 0) begin
        d_act = 1; data_wr = 1'($urandom); data_size = sizes[$urandom_range(2)];
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      inst_req    = i_act;
      data_req    = d_act;
      bus_addr_ok = 1'($urandom);
      bus_data_ok = (mq.size() > 0) ? ($urandom_range(4) < 2) : ($urandom_range(399) == 0);
      bus_rdata   = $urandom;
      #2;
      // Which requester the spec says owns the address phase this cycle.
      ev = 0; eo = 0;
      if (resetn) begin
        if (m_lock >= 0) begin ev = 1; eo = m_lock[0]; end
        else if (mq.size() < MAXO && (i_act || d_act)) begin
          ev = 1;
`ifdef BUS_ARB_RR_EN
          eo = (i_act && d_act) ? ~m_last : d_act;
`else
          eo = d_act;
`endif
        end
      end
      e_ia  = ev && bus_addr_ok && !eo;
      e_da  = ev && bus_addr_ok && eo;
      e_idk = resetn && bus_data_ok && mq.size() > 0 && mq[0] == 0;
      e_ddk = resetn && bus_data_ok && mq.size() > 0 && mq[0] == 1;
      e_err = resetn && m_err;
      exp_hs = {ev, e_ia, e_da, e_idk, e_ddk, e_err};
      got_hs = {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, protocol_err};
      exp_pl = '0;
      if (ev && eo)  exp_pl[134:64] = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
      if (ev && !eo) exp_pl[134:64] = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
      exp_pl[63:0] = {bus_rdata, bus_rdata};
      got_pl = {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata, inst_rdata, data_rdata};
      total++; if (got_hs !== exp_hs)
        begin bad++; $display("FAIL rand_hs cyc%0d: got %b want %b", cyc, got_hs, exp_hs); end
      total++; if (got_pl !== exp_pl)
        begin bad++; $display("FAIL rand_payload cyc%0d: got %h want %h", cyc, got_pl, exp_pl); end
      if (!resetn) begin
        mq.delete(); m_lock = -1; m_err = 0; m_last = 0;
      end else begin
        if (bus_data_ok) begin
          if (mq.size() > 0) void'(mq.pop_front());
          else m_err = 1;
        end
        if (ev) begin
          if (bus_addr_ok) begin
            mq.push_back(eo); m_lock = -1; m_last = eo;
            if (eo) d_act = 0; else i_act = 0;
          end else begin
            m_lock = eo ? 1 : 0;
          end
        end
      end
      @(negedge clk);
    end
    resetn = 1;
    idle_inputs();
  endtask

  initial begin
    resetn = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_inst_single();
    test_priority();
    test_lock();
    test_full();
    test_spurious();
    test_tie();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
